dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache controller between the pipeline's MEM stage (EX/MEM address, store data and read/write controls) and a slow line-granular data memory. Hits complete in the MEM cycle with no stall. Misses raise `stall_o`, which freezes PC and all pipeline registers, while the controller writes back a dirty victim and refills the line. Tag, valid, dirty and data arrays are internal flops.

---
 rtl/dcache_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Hits are served combinationally in the MEM cycle. A miss stalls the
// pipeline while a dirty victim is written back and the line is refilled.
// Memory-side outputs are registered from the FSM and the latched miss address.
module dcache_ctrl #(
  parameter int INDEX_BITS  = 5,
  parameter int MEM_LAT_MAX = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic         we_i,
  input  logic [31:0]  addr_i,
  input  logic [31:0]  wdata_i,
  output logic [31:0]  rdata_o,
  output logic         stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic [255:0] mem_rdata_i,
  input  logic         mem_ack_i,
  output logic         err_o
);

  localparam int         LINES   = 1 << INDEX_BITS;
  localparam int         TAG_W   = 27 - INDEX_BITS;
  localparam logic [7:0] LAT_MAX = 8'(MEM_LAT_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      miss_addr_q;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [255:0]     mem_wdata_q, mem_wdata_d;
  logic [7:0]       wd_q, wd_d;
  logic             err_q, err_d;
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [255:0]     line_q [LINES];

  logic [INDEX_BITS-1:0] idx_s, miss_idx_s;
  logic [TAG_W-1:0]      tag_s, miss_tag_s;
  logic [2:0]            off_s;
  logic                  hit_s, idle_hit_s, miss_s, wait_s, ack_s;
  logic [31:0]           hit_word_s;
  logic                  unused_s;

  assign idx_s      = addr_i[INDEX_BITS+4:5];
  assign tag_s      = addr_i[31:INDEX_BITS+5];
  assign off_s      = addr_i[4:2];
  assign miss_idx_s = miss_addr_q[INDEX_BITS+4:5];
  assign miss_tag_s = miss_addr_q[31:INDEX_BITS+5];

  assign hit_s      = req_i & valid_q[idx_s] & (tag_q[idx_s] == tag_s);
  assign idle_hit_s = (state_q == S_IDLE) & hit_s;
  assign miss_s     = (state_q == S_IDLE) & req_i & ~hit_s;
  assign wait_s     = (state_q == S_WB) | (state_q == S_FILL);
  assign ack_s      = wait_s & mem_ack_i;
  assign hit_word_s = line_q[idx_s][{off_s, 5'b00000} +: 32];

  // Byte-offset bits and the line offset of the latched miss address carry no meaning here.
  assign unused_s = ^{addr_i[1:0], miss_addr_q[4:0]};

  // Load data only on an IDLE hit; zero otherwise (including no request).
  assign rdata_o = idle_hit_s ? hit_word_s : 32'd0;

  // Freeze in every non-IDLE state plus the cycle a miss is detected; reset forces it low.
  assign stall_o = rst_i & ((state_q != S_IDLE) | miss_s);

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;

  // Next-state, next memory-port values and watchdog update.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wd_d        = 8'd0;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (miss_s) begin
          mem_req_d = 1'b1;
          if (valid_q[idx_s] & dirty_q[idx_s]) begin
            state_d     = S_WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[idx_s], idx_s, 5'b00000};
            mem_wdata_d = line_q[idx_s];
          end else begin
            state_d    = S_FILL;
            mem_we_d   = 1'b0;
            mem_addr_d = {tag_s, idx_s, 5'b00000};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB, S_FILL: begin
        if (mem_ack_i) begin
          wd_d = 8'd0;
          if (state_q == S_WB) begin
            state_d    = S_FILL;
            mem_we_d   = 1'b0;
            mem_addr_d = {miss_tag_s, miss_idx_s, 5'b00000};
          end else begin
            state_d   = S_DONE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
          end
        end else begin
          // Saturating count of ack-less cycles; keeps waiting after flagging.
          if (wd_q != LAT_MAX) begin
            wd_d = wd_q + 8'd1;
          end else begin
            wd_d = wd_q;
          end
          if (wd_d == LAT_MAX) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // FSM state, registered memory port, watchdog, miss address and valid/dirty bits.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      miss_addr_q <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 256'd0;
      wd_q        <= 8'd0;
      err_q       <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      if (miss_s) begin
        miss_addr_q <= addr_i;
      end
      if (ack_s && (state_q == S_FILL)) begin
        valid_q[miss_idx_s] <= 1'b1;
        dirty_q[miss_idx_s] <= 1'b0;
      end else if (ack_s && (state_q == S_WB)) begin
        dirty_q[miss_idx_s] <= 1'b0;
      end else if (idle_hit_s && we_i) begin
        dirty_q[idx_s] <= 1'b1;
      end
    end
  end

  // Tag and data arrays: refill on FILL ack, word write on a store hit.
  always_ff @(posedge clk_i) begin
    if (ack_s && (state_q == S_FILL)) begin
      line_q[miss_idx_s] <= mem_rdata_i;
      tag_q[miss_idx_s]  <= miss_tag_s;
    end else if (idle_hit_s && we_i) begin
      line_q[idx_s][{off_s, 5'b00000} +: 32] <= wdata_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl: directed scenarios plus a randomized access stream,
// checked against an architectural word memory, a backing line memory and a
// residency model of which line each index holds.
module tb_dcache_ctrl;
  localparam int MAXL = 4;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         req_i = 1'b0;
  logic         we_i = 1'b0;
  logic [31:0]  addr_i = 32'd0;
  logic [31:0]  wdata_i = 32'd0;
  logic [31:0]  rdata_o;
  logic         stall_o, mem_req_o, mem_we_o, err_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i = 256'd0;
  logic         mem_ack_i = 1'b0;

  dcache_ctrl #(.INDEX_BITS(5), .MEM_LAT_MAX(MAXL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Backing memory by line number, architectural memory by word number.
  logic [255:0] bmem [int];
  logic [31:0]  arch [int];
  // Which line each index holds.
  logic [21:0]  m_tag   [32];
  logic         m_val   [32];
  logic         m_dirty [32];
  logic         m_err;

  // Expectations for the next access.
  bit           exp_hit, exp_wb;
  logic [31:0]  exp_wb_addr, exp_fill_addr, exp_rdata;
  logic [255:0] exp_wb_data;
  int           exp_stall;

  // Observations of the last access.
  int           obs_stall, obs_wb, obs_fill, obs_fill_len;
  bit           obs_timeout;
  logic [31:0]  obs_wb_addr, obs_fill_addr, obs_rdata;
  logic [255:0] obs_wb_data;
  logic         fill_err [$];

  function automatic logic [255:0] bmem_rd(input int line);
    logic [255:0] l;
    if (bmem.exists(line)) return bmem[line];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'((line * 8 + w) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    return l;
  endfunction

  function automatic logic [31:0] arch_rd(input int waddr);
    logic [255:0] l;
    if (arch.exists(waddr)) return arch[waddr];
    l = bmem_rd(waddr >> 3);
    return l[(waddr & 7) * 32 +: 32];
  endfunction

  function automatic logic [255:0] arch_line(input int line);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = arch_rd(line * 8 + w);
    return l;
  endfunction

  // Reset loses the cache: architectural state reverts to what memory holds.
  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i] = 22'd0;
    end
    m_err = 1'b0;
    arch.delete();
  endtask

  // Derive what an access must produce, then apply it to the model.
  task automatic predict(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input int lwb, input int lfill);
    logic [4:0]  idx;
    logic [21:0] tg;
    idx = a[9:5];
    tg  = a[31:10];
    exp_hit       = m_val[idx] && (m_tag[idx] == tg);
    exp_wb        = !exp_hit && m_val[idx] && m_dirty[idx];
    exp_wb_addr   = {m_tag[idx], idx, 5'b00000};
    exp_wb_data   = arch_line(int'({m_tag[idx], idx}));
    exp_fill_addr = {a[31:5], 5'b00000};
    exp_stall     = exp_hit ? 0 : 2 + (lfill + 1) + (exp_wb ? lwb + 1 : 0);
    if (!exp_hit) begin
      if (lfill >= MAXL || (exp_wb && lwb >= MAXL)) m_err = 1'b1;
      m_val[idx]   = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    exp_rdata = arch_rd(int'(a >> 2));
    if (we) begin
      arch[int'(a >> 2)] = d;
      m_dirty[idx] = 1'b1;
    end
  endtask

  // Issue one held access, act as the memory (ack after lwb/lfill cycles) and record what happens.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input int lwb, input int lfill);
    int pc;
    logic prev_req, prev_we;
    logic [31:0] prev_addr;
    bit done;
    obs_stall = 0; obs_wb = 0; obs_fill = 0; obs_fill_len = 0; obs_timeout = 1'b0;
    obs_wb_addr = 32'd0; obs_fill_addr = 32'd0; obs_rdata = 32'd0; obs_wb_data = 256'd0;
    fill_err.delete();
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d;
    prev_req = 1'b0; prev_we = 1'b0; prev_addr = 32'd0; pc = 0; done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        if (!prev_req || mem_we_o !== prev_we || mem_addr_o !== prev_addr) begin
          pc = 0;
          if (mem_we_o) begin
            obs_wb++; obs_wb_addr = mem_addr_o; obs_wb_data = mem_wdata_o;
          end else begin
            obs_fill++; obs_fill_addr = mem_addr_o;
          end
        end
        if (!mem_we_o) begin
          obs_fill_len++;
          fill_err.push_back(err_o);
        end
        if (pc == (mem_we_o ? lwb : lfill)) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) bmem[int'(mem_addr_o >> 5)] = mem_wdata_o;
          else mem_rdata_i = bmem_rd(int'(mem_addr_o >> 5));
        end
        pc++;
      end
      prev_req = mem_req_o; prev_we = mem_we_o; prev_addr = mem_addr_o;
      if (stall_o) obs_stall++;
      else begin
        obs_rdata = rdata_o;
        done = 1'b1;
      end
    end
    obs_timeout = !done;
    @(posedge clk_i); #1;
    req_i = 1'b0; we_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #2 rst_i = 1'b0;
    #10;
    checks++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl stall/req/we got %b%b%b want 000", stall_o, mem_req_o, mem_we_o); end
    checks++; if (mem_addr_o !== 32'd0) begin
      errors++; $display("FAIL reset_addr got %h want 0", mem_addr_o); end
    checks++; if (mem_wdata_o !== 256'd0) begin
      errors++; $display("FAIL reset_wdata got %h want 0", mem_wdata_o); end
    checks++; if (rdata_o !== 32'd0 || err_o !== 1'b0) begin
      errors++; $display("FAIL reset_rdata_err got %h/%b want 0/0", rdata_o, err_o); end
    req_i = 1'b1; addr_i = 32'h0000_0040; #1;
    checks++; if (stall_o !== 1'b0) begin
      errors++; $display("FAIL reset_stall_with_req got %b want 0", stall_o); end
    req_i = 1'b0; addr_i = 32'd0;
    @(negedge clk_i); rst_i = 1'b1;
  endtask

  task automatic test_cold_load();
    logic [255:0] l;
    l = bmem_rd(2);
    l[31:0] = 32'hDEAD_BEEF;
    bmem[2] = l;
    predict(1'b0, 32'h0000_0040, 32'd0, 0, 0);
    access(1'b0, 32'h0000_0040, 32'd0, 0, 0);
    checks++; if (obs_fill != 1 || obs_fill_addr !== 32'h0000_0040 || obs_wb != 0) begin
      errors++; $display("FAIL cold_fill fills %0d addr %h wbs %0d want 1 00000040 0", obs_fill, obs_fill_addr, obs_wb); end
    checks++; if (obs_stall != 3) begin
      errors++; $display("FAIL cold_stall got %0d want 3", obs_stall); end
    checks++; if (obs_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL cold_rdata got %h want deadbeef", obs_rdata); end
  endtask

  task automatic test_store_conflict();
    predict(1'b1, 32'h0000_0044, 32'h1234_5678, 0, 0);
    access(1'b1, 32'h0000_0044, 32'h1234_5678, 0, 0);
    checks++; if (obs_stall != 0) begin
      errors++; $display("FAIL store_hit_stall got %0d want 0", obs_stall); end
    predict(1'b0, 32'h0000_0440, 32'd0, 0, 0);
    access(1'b0, 32'h0000_0440, 32'd0, 0, 0);
    checks++; if (obs_wb != 1 || obs_wb_addr !== 32'h0000_0040 || obs_wb_data[63:32] !== 32'h1234_5678) begin
      errors++; $display("FAIL conflict_wb count %0d addr %h word1 %h want 1 00000040 12345678",
                         obs_wb, obs_wb_addr, obs_wb_data[63:32]); end
    checks++; if (obs_wb_data !== exp_wb_data) begin
      errors++; $display("FAIL conflict_wb_line got %h want %h", obs_wb_data, exp_wb_data); end
    checks++; if (obs_fill != 1 || obs_fill_addr !== 32'h0000_0440) begin
      errors++; $display("FAIL conflict_fill count %0d addr %h want 1 00000440", obs_fill, obs_fill_addr); end
    checks++; if (obs_stall != 4 || obs_rdata !== exp_rdata) begin
      errors++; $display("FAIL conflict_stall_rdata got %0d/%h want 4/%h", obs_stall, obs_rdata, exp_rdata); end
  endtask

  task automatic test_spurious_ack();
    logic [31:0] a, d;
    logic w;
    for (int i = 0; i < 8; i++) begin
      a = 32'h0000_0440 + 32'(4 * ((i * 3) % 8));
      w = (i % 3 == 0);
      d = $urandom;
      predict(w, a, d, 0, 0);
      @(posedge clk_i); #1;
      req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
      mem_ack_i = i[0]; mem_rdata_i = {8{$urandom}};
      @(negedge clk_i);
      checks++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
        errors++; $display("FAIL spurious_stall step %0d stall %b req %b want 0 0", i, stall_o, mem_req_o); end
      if (!w) begin
        checks++; if (rdata_o !== exp_rdata) begin
          errors++; $display("FAIL spurious_rdata step %0d got %h want %h", i, rdata_o, exp_rdata); end
      end
    end
    @(posedge clk_i); #1;
    req_i = 1'b0; we_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic test_watchdog();
    predict(1'b0, 32'h0000_0880, 32'd0, 0, 6);
    access(1'b0, 32'h0000_0880, 32'd0, 0, 6);
    checks++; if (fill_err.size() != 7) begin
      errors++; $display("FAIL wd_fill_len got %0d want 7", fill_err.size()); end
    else begin
      checks++; if (fill_err[3] !== 1'b0 || fill_err[4] !== 1'b1) begin
        errors++; $display("FAIL wd_err_timing cycle4 %b cycle5 %b want 0 1", fill_err[3], fill_err[4]); end
    end
    checks++; if (err_o !== 1'b1) begin
      errors++; $display("FAIL wd_err_sticky got %b want 1", err_o); end
    checks++; if (obs_stall != 9 || obs_rdata !== exp_rdata) begin
      errors++; $display("FAIL wd_refill stall %0d rdata %h want 9 %h", obs_stall, obs_rdata, exp_rdata); end
  endtask

  task automatic test_slow_memory();
    predict(1'b0, 32'h0000_08A4, 32'd0, 0, 5);
    access(1'b0, 32'h0000_08A4, 32'd0, 0, 5);
    checks++; if (obs_fill != 1 || obs_fill_len != 6 || obs_fill_addr !== 32'h0000_08A0) begin
      errors++; $display("FAIL slow_fill phases %0d len %0d addr %h want 1 6 000008a0",
                         obs_fill, obs_fill_len, obs_fill_addr); end
    checks++; if (obs_stall != 8 || obs_rdata !== exp_rdata) begin
      errors++; $display("FAIL slow_stall_rdata got %0d/%h want 8/%h", obs_stall, obs_rdata, exp_rdata); end
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    seen = 1'b0;
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0900;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_i);
      if (mem_req_o === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin
      errors++; $display("FAIL rmf_no_fill mem_req_o %b want 1", mem_req_o); end
    #2 rst_i = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL rmf_drop req %b stall %b err %b want 0 0 0", mem_req_o, stall_o, err_o); end
    model_reset();
    req_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    predict(1'b0, 32'h0000_0900, 32'd0, 0, 0);
    access(1'b0, 32'h0000_0900, 32'd0, 0, 0);
    checks++; if (obs_fill != 1 || obs_stall != 3 || obs_rdata !== exp_rdata) begin
      errors++; $display("FAIL rmf_remiss fills %0d stall %0d rdata %h want 1 3 %h",
                         obs_fill, obs_stall, obs_rdata, exp_rdata); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic w;
    int lwb, lfill;
    for (int i = 0; i < 80; i++) begin
      a = {20'd0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      lwb = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 2);
      lfill = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 2);
      predict(w, a, d, lwb, lfill);
      access(w, a, d, lwb, lfill);
      checks++; if (obs_timeout || obs_stall != exp_stall) begin
        errors++; $display("FAIL rnd_stall #%0d addr %h timeout %b got %0d want %0d", i, a, obs_timeout, obs_stall, exp_stall); end
      if (!w) begin
        checks++; if (obs_rdata !== exp_rdata) begin
          errors++; $display("FAIL rnd_rdata #%0d addr %h got %h want %h", i, a, obs_rdata, exp_rdata); end
      end
      checks++; if (obs_wb != (exp_wb ? 1 : 0) || obs_fill != (exp_hit ? 0 : 1)) begin
        errors++; $display("FAIL rnd_phases #%0d wbs %0d fills %0d want %0d %0d", i, obs_wb, obs_fill,
                           exp_wb ? 1 : 0, exp_hit ? 0 : 1); end
      if (exp_wb) begin
        checks++; if (obs_wb_addr !== exp_wb_addr || obs_wb_data !== exp_wb_data) begin
          errors++; $display("FAIL rnd_wb #%0d addr %h want %h data %h want %h", i, obs_wb_addr, exp_wb_addr,
                             obs_wb_data, exp_wb_data); end
      end
      if (!exp_hit) begin
        checks++; if (obs_fill_addr !== exp_fill_addr) begin
          errors++; $display("FAIL rnd_fill_addr #%0d got %h want %h", i, obs_fill_addr, exp_fill_addr); end
      end
      checks++; if (err_o !== m_err) begin
        errors++; $display("FAIL rnd_err #%0d got %b want %b", i, err_o, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_conflict();
    test_spurious_ack();
    test_watchdog();
    test_slow_memory();
    test_reset_mid_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
